// File: rtl/axi4_lite_master_dual.sv
// AXI4-Lite master with independent read and write engines behind valid/ready
// command/response streams; all bus-side outputs are registered.
module axi4_lite_master_dual #(
  parameter int  ADDRESS        = 32,
  parameter int  DATA_WIDTH     = 32,
  parameter int  TIMEOUT_CYCLES = 0,
  localparam int STRB_W         = DATA_WIDTH / 8
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  // local write command / response
  input  logic                  WR_CMD_VALID,
  output logic                  WR_CMD_READY,
  input  logic [ADDRESS-1:0]    WR_CMD_ADDR,
  input  logic [DATA_WIDTH-1:0] WR_CMD_DATA,
  input  logic [STRB_W-1:0]     WR_CMD_STRB,
  output logic                  WR_RSP_VALID,
  input  logic                  WR_RSP_READY,
  output logic [1:0]            WR_RSP_RESP,
  output logic                  WR_RSP_TIMEOUT,
  // local read command / response
  input  logic                  RD_CMD_VALID,
  output logic                  RD_CMD_READY,
  input  logic [ADDRESS-1:0]    RD_CMD_ADDR,
  output logic                  RD_RSP_VALID,
  input  logic                  RD_RSP_READY,
  output logic [DATA_WIDTH-1:0] RD_RSP_DATA,
  output logic [1:0]            RD_RSP_RESP,
  output logic                  RD_RSP_TIMEOUT,
  // AXI4-Lite master
  output logic [ADDRESS-1:0]    M_AWADDR,
  output logic                  M_AWVALID,
  input  logic                  M_AWREADY,
  output logic [DATA_WIDTH-1:0] M_WDATA,
  output logic [STRB_W-1:0]     M_WSTRB,
  output logic                  M_WVALID,
  input  logic                  M_WREADY,
  input  logic [1:0]            M_BRESP,
  input  logic                  M_BVALID,
  output logic                  M_BREADY,
  output logic [ADDRESS-1:0]    M_ARADDR,
  output logic                  M_ARVALID,
  input  logic                  M_ARREADY,
  input  logic [DATA_WIDTH-1:0] M_RDATA,
  input  logic [1:0]            M_RRESP,
  input  logic                  M_RVALID,
  output logic                  M_RREADY
);

  localparam bit TO_EN = (TIMEOUT_CYCLES > 0);
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_EN ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_RESP, W_DONE} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA, R_DONE} r_state_t;

  w_state_t         w_state, w_next;
  r_state_t         r_state, r_next;
  logic             aw_done, dat_done, wr_stale, rd_stale;
  logic [CNT_W-1:0] wr_cnt, rd_cnt;

  logic wr_accept, rd_accept, aw_hs, dat_hs, b_hs, ar_hs, r_hs;
  logic both_done, wr_to, rd_to;

  assign wr_accept = WR_CMD_VALID && WR_CMD_READY;
  assign rd_accept = RD_CMD_VALID && RD_CMD_READY;
  assign aw_hs     = M_AWVALID && M_AWREADY;
  assign dat_hs    = M_WVALID && M_WREADY;
  assign b_hs      = M_BVALID && M_BREADY;
  assign ar_hs     = M_ARVALID && M_ARREADY;
  assign r_hs      = M_RVALID && M_RREADY;
  // AW and W may finish in either order or together; exit as soon as both are known done
  assign both_done = (aw_done || aw_hs) && (dat_done || dat_hs);
  assign wr_to     = TO_EN && (wr_cnt == TO_LAST);
  assign rd_to     = TO_EN && (rd_cnt == TO_LAST);

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
    end else begin
      w_state <= w_next;
      r_state <= r_next;
    end
  end

  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE:  if (wr_accept) w_next = W_ADDR;
      W_ADDR:  if (both_done) w_next = W_RESP;
      W_RESP:  if (b_hs || wr_to) w_next = W_DONE;
      W_DONE:  if (WR_RSP_READY) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (rd_accept) r_next = R_ADDR;
      R_ADDR:  if (ar_hs) r_next = R_DATA;
      R_DATA:  if (r_hs || rd_to) r_next = R_DONE;
      R_DONE:  if (RD_RSP_READY) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  // Command ready is held low during reset so no command is accepted and then dropped
  always_comb begin
    WR_CMD_READY = ARESETN && (w_state == W_IDLE) && !wr_stale;
    RD_CMD_READY = ARESETN && (r_state == R_IDLE) && !rd_stale;
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      M_AWADDR       <= '0;
      M_AWVALID      <= 1'b0;
      M_WDATA        <= '0;
      M_WSTRB        <= '0;
      M_WVALID       <= 1'b0;
      M_BREADY       <= 1'b0;
      aw_done        <= 1'b0;
      dat_done       <= 1'b0;
      wr_stale       <= 1'b0;
      wr_cnt         <= '0;
      WR_RSP_VALID   <= 1'b0;
      WR_RSP_RESP    <= 2'b00;
      WR_RSP_TIMEOUT <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: if (wr_accept) begin
          M_AWADDR  <= WR_CMD_ADDR;
          M_WDATA   <= WR_CMD_DATA;
          M_WSTRB   <= WR_CMD_STRB;
          M_AWVALID <= 1'b1;
          M_WVALID  <= 1'b1;
          aw_done   <= 1'b0;
          dat_done  <= 1'b0;
        end
        W_ADDR: begin
          if (aw_hs) begin
            M_AWVALID <= 1'b0;
            aw_done   <= 1'b1;
          end
          if (dat_hs) begin
            M_WVALID <= 1'b0;
            dat_done <= 1'b1;
          end
          if (both_done) begin
            M_BREADY <= 1'b1;
            wr_cnt   <= '0;
          end
        end
        W_RESP: begin
          if (b_hs) begin
            WR_RSP_RESP    <= M_BRESP;
            WR_RSP_TIMEOUT <= 1'b0;
            WR_RSP_VALID   <= 1'b1;
            M_BREADY       <= 1'b0;
          end else if (wr_to) begin
            // BREADY stays up so the late beat is swallowed instead of hitting the next write
            WR_RSP_RESP    <= 2'b10;
            WR_RSP_TIMEOUT <= 1'b1;
            WR_RSP_VALID   <= 1'b1;
            wr_stale       <= 1'b1;
          end else begin
            wr_cnt <= wr_cnt + 1'b1;
          end
        end
        W_DONE: if (WR_RSP_READY) WR_RSP_VALID <= 1'b0;
        default: ;
      endcase
      if (wr_stale && b_hs) begin
        wr_stale <= 1'b0;
        M_BREADY <= 1'b0;
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      M_ARADDR       <= '0;
      M_ARVALID      <= 1'b0;
      M_RREADY       <= 1'b0;
      rd_stale       <= 1'b0;
      rd_cnt         <= '0;
      RD_RSP_VALID   <= 1'b0;
      RD_RSP_DATA    <= '0;
      RD_RSP_RESP    <= 2'b00;
      RD_RSP_TIMEOUT <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: if (rd_accept) begin
          M_ARADDR  <= RD_CMD_ADDR;
          M_ARVALID <= 1'b1;
        end
        R_ADDR: if (ar_hs) begin
          M_ARVALID <= 1'b0;
          M_RREADY  <= 1'b1;
          rd_cnt    <= '0;
        end
        R_DATA: begin
          if (r_hs) begin
            RD_RSP_DATA    <= M_RDATA;
            RD_RSP_RESP    <= M_RRESP;
            RD_RSP_TIMEOUT <= 1'b0;
            RD_RSP_VALID   <= 1'b1;
            M_RREADY       <= 1'b0;
          end else if (rd_to) begin
            RD_RSP_DATA    <= '0;
            RD_RSP_RESP    <= 2'b10;
            RD_RSP_TIMEOUT <= 1'b1;
            RD_RSP_VALID   <= 1'b1;
            rd_stale       <= 1'b1;
          end else begin
            rd_cnt <= rd_cnt + 1'b1;
          end
        end
        R_DONE: if (RD_RSP_READY) RD_RSP_VALID <= 1'b0;
        default: ;
      endcase
      if (rd_stale && r_hs) begin
        rd_stale <= 1'b0;
        M_RREADY <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axi4_lite_master_dual.sv
// Bench for axi4_lite_master_dual: table vectors, random transactions against a
// latency/response model, plus reset and concurrency sequences.
module tb_axi4_lite_master_dual;

  localparam int TO = 8;

  logic        ACLK = 1'b0, ARESETN = 1'b0;
  logic        WR_CMD_VALID = 0, WR_CMD_READY;
  logic [31:0] WR_CMD_ADDR = 0, WR_CMD_DATA = 0;
  logic [3:0]  WR_CMD_STRB = 0;
  logic        WR_RSP_VALID, WR_RSP_READY = 0, WR_RSP_TIMEOUT;
  logic [1:0]  WR_RSP_RESP;
  logic        RD_CMD_VALID = 0, RD_CMD_READY;
  logic [31:0] RD_CMD_ADDR = 0;
  logic        RD_RSP_VALID, RD_RSP_READY = 0, RD_RSP_TIMEOUT;
  logic [31:0] RD_RSP_DATA;
  logic [1:0]  RD_RSP_RESP;
  logic [31:0] M_AWADDR, M_WDATA, M_ARADDR, M_RDATA = 0;
  logic [3:0]  M_WSTRB;
  logic        M_AWVALID, M_AWREADY = 0, M_WVALID, M_WREADY = 0;
  logic [1:0]  M_BRESP = 0, M_RRESP = 0;
  logic        M_BVALID = 0, M_BREADY, M_ARVALID, M_ARREADY = 0, M_RVALID = 0, M_RREADY;

  int checks = 0, errors = 0, cyc = 0;

  axi4_lite_master_dual #(.ADDRESS(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .WR_CMD_VALID(WR_CMD_VALID), .WR_CMD_READY(WR_CMD_READY), .WR_CMD_ADDR(WR_CMD_ADDR),
    .WR_CMD_DATA(WR_CMD_DATA), .WR_CMD_STRB(WR_CMD_STRB),
    .WR_RSP_VALID(WR_RSP_VALID), .WR_RSP_READY(WR_RSP_READY), .WR_RSP_RESP(WR_RSP_RESP),
    .WR_RSP_TIMEOUT(WR_RSP_TIMEOUT),
    .RD_CMD_VALID(RD_CMD_VALID), .RD_CMD_READY(RD_CMD_READY), .RD_CMD_ADDR(RD_CMD_ADDR),
    .RD_RSP_VALID(RD_RSP_VALID), .RD_RSP_READY(RD_RSP_READY), .RD_RSP_DATA(RD_RSP_DATA),
    .RD_RSP_RESP(RD_RSP_RESP), .RD_RSP_TIMEOUT(RD_RSP_TIMEOUT),
    .M_AWADDR(M_AWADDR), .M_AWVALID(M_AWVALID), .M_AWREADY(M_AWREADY),
    .M_WDATA(M_WDATA), .M_WSTRB(M_WSTRB), .M_WVALID(M_WVALID), .M_WREADY(M_WREADY),
    .M_BRESP(M_BRESP), .M_BVALID(M_BVALID), .M_BREADY(M_BREADY),
    .M_ARADDR(M_ARADDR), .M_ARVALID(M_ARVALID), .M_ARREADY(M_ARREADY),
    .M_RDATA(M_RDATA), .M_RRESP(M_RRESP), .M_RVALID(M_RVALID), .M_RREADY(M_RREADY)
  );

  always #5 ACLK = ~ACLK;
  always @(posedge ACLK) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // d1 = AW/AR ready delay, d2 = W ready delay, d3 = B/R valid delay (cycles of READY seen)
  typedef struct {
    string       name;
    bit          isWr;
    logic [31:0] addr, data;
    logic [3:0]  strb;
    int          d1, d2, d3;
    logic [1:0]  resp;
    int          rspDly;
    int          expLat;
    logic [1:0]  expResp;
    logic        expTo;
    logic [31:0] expData;
  } vec_t;

  typedef struct {
    int          lat, acc, vCnt1, vCnt2, rdyCnt, stabErr, busyErr;
    logic [1:0]  resp;
    logic        tout, endReady, hung;
    logic [31:0] data;
  } res_t;

  function automatic vec_t mk(string n, bit w, logic [31:0] a, logic [31:0] d, logic [3:0] s,
                              int d1, int d2, int d3, logic [1:0] rsp, int rd,
                              int el, logic [1:0] er, logic et, logic [31:0] ed);
    vec_t v;
    v.name = n; v.isWr = w; v.addr = a; v.data = d; v.strb = s;
    v.d1 = d1; v.d2 = d2; v.d3 = d3; v.resp = rsp; v.rspDly = rd;
    v.expLat = el; v.expResp = er; v.expTo = et; v.expData = ed;
    return v;
  endfunction

  // Reference: response appears 2 cycles after the later address/data handshake plus the
  // slave's response delay, or TO cycles after entering the response wait if that is shorter.
  function automatic vec_t model(vec_t v);
    int  mx;
    bit  timed;
    mx = v.isWr ? ((v.d1 > v.d2) ? v.d1 : v.d2) : v.d1;
    timed = (v.d3 >= TO);
    v.expLat  = timed ? (1 + mx + TO) : (2 + mx + v.d3);
    v.expResp = timed ? 2'b10 : v.resp;
    v.expTo   = timed;
    v.expData = (v.isWr || timed) ? 32'h0 : v.data;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic doWrite(input vec_t v, output res_t r);
    int awC, wC, bC, rspC, guard, t;
    bit bGiven, rspSeen, rspDone, rspDonePrev, bGivenPrev;
    r = '{default: 0};
    r.lat = -1;
    awC = 0; wC = 0; bC = 0; rspC = 0; guard = 0; t = 0;
    bGiven = 0; rspSeen = 0; rspDone = 0;
    @(negedge ACLK);
    WR_CMD_VALID = 1; WR_CMD_ADDR = v.addr; WR_CMD_DATA = v.data; WR_CMD_STRB = v.strb;
    while (!WR_CMD_READY && guard < 50) begin @(negedge ACLK); guard++; end
    if (!WR_CMD_READY) begin r.hung = 1; WR_CMD_VALID = 0; return; end
    @(negedge ACLK);
    r.acc = cyc;
    WR_CMD_VALID = 0;
    WR_RSP_READY = (v.rspDly == 0);
    while (!(rspDone && bGiven) && t < 100) begin
      rspDonePrev = rspDone; bGivenPrev = bGiven;
      if (WR_CMD_READY && (!rspDonePrev || (r.tout && !bGivenPrev))) r.busyErr++;
      if (M_AWVALID) begin
        if (M_AWADDR !== v.addr) r.stabErr++;
        M_AWREADY = (awC >= v.d1); awC++;
      end else M_AWREADY = 0;
      if (M_WVALID) begin
        if (M_WDATA !== v.data || M_WSTRB !== v.strb) r.stabErr++;
        M_WREADY = (wC >= v.d2); wC++;
      end else M_WREADY = 0;
      if (M_BREADY) begin
        M_BVALID = !bGiven && (bC >= v.d3); M_BRESP = v.resp;
        if (M_BVALID) bGiven = 1;
        bC++;
      end else M_BVALID = 0;
      if (WR_RSP_VALID) begin
        if (rspDone) begin r.stabErr++; WR_RSP_READY = 0; end
        else begin
          if (!rspSeen) begin r.lat = t; r.resp = WR_RSP_RESP; r.tout = WR_RSP_TIMEOUT; rspSeen = 1; end
          else if (WR_RSP_RESP !== r.resp || WR_RSP_TIMEOUT !== r.tout) r.stabErr++;
          WR_RSP_READY = (rspC >= v.rspDly);
          if (WR_RSP_READY) rspDone = 1;
          rspC++;
        end
      end else WR_RSP_READY = !rspSeen && (v.rspDly == 0);
      @(negedge ACLK); t++;
    end
    r.hung = !(rspDone && bGiven);
    M_AWREADY = 0; M_WREADY = 0; M_BVALID = 0; WR_RSP_READY = 0;
    if (WR_RSP_VALID) r.stabErr++;
    r.endReady = WR_CMD_READY;
    r.vCnt1 = awC; r.vCnt2 = wC; r.rdyCnt = bC;
  endtask

  task automatic doRead(input vec_t v, output res_t r);
    int arC, rC, rspC, guard, t;
    bit rGiven, rspSeen, rspDone, rspDonePrev, rGivenPrev;
    r = '{default: 0};
    r.lat = -1;
    arC = 0; rC = 0; rspC = 0; guard = 0; t = 0;
    rGiven = 0; rspSeen = 0; rspDone = 0;
    @(negedge ACLK);
    RD_CMD_VALID = 1; RD_CMD_ADDR = v.addr;
    while (!RD_CMD_READY && guard < 50) begin @(negedge ACLK); guard++; end
    if (!RD_CMD_READY) begin r.hung = 1; RD_CMD_VALID = 0; return; end
    @(negedge ACLK);
    r.acc = cyc;
    RD_CMD_VALID = 0;
    RD_RSP_READY = (v.rspDly == 0);
    while (!(rspDone && rGiven) && t < 100) begin
      rspDonePrev = rspDone; rGivenPrev = rGiven;
      if (RD_CMD_READY && (!rspDonePrev || (r.tout && !rGivenPrev))) r.busyErr++;
      if (M_RREADY && M_ARVALID) r.stabErr++;
      if (M_ARVALID) begin
        if (M_ARADDR !== v.addr) r.stabErr++;
        M_ARREADY = (arC >= v.d1); arC++;
      end else M_ARREADY = 0;
      if (M_RREADY) begin
        M_RVALID = !rGiven && (rC >= v.d3); M_RDATA = v.data; M_RRESP = v.resp;
        if (M_RVALID) rGiven = 1;
        rC++;
      end else M_RVALID = 0;
      if (RD_RSP_VALID) begin
        if (rspDone) begin r.stabErr++; RD_RSP_READY = 0; end
        else begin
          if (!rspSeen) begin
            r.lat = t; r.resp = RD_RSP_RESP; r.tout = RD_RSP_TIMEOUT; r.data = RD_RSP_DATA; rspSeen = 1;
          end else if (RD_RSP_RESP !== r.resp || RD_RSP_TIMEOUT !== r.tout || RD_RSP_DATA !== r.data)
            r.stabErr++;
          RD_RSP_READY = (rspC >= v.rspDly);
          if (RD_RSP_READY) rspDone = 1;
          rspC++;
        end
      end else RD_RSP_READY = !rspSeen && (v.rspDly == 0);
      @(negedge ACLK); t++;
    end
    r.hung = !(rspDone && rGiven);
    M_ARREADY = 0; M_RVALID = 0; RD_RSP_READY = 0;
    if (RD_RSP_VALID) r.stabErr++;
    r.endReady = RD_CMD_READY;
    r.vCnt1 = arC; r.rdyCnt = rC;
  endtask

  task automatic applyStimulus(input vec_t v, output int acc);
    res_t r;
    if (v.isWr) doWrite(v, r); else doRead(v, r);
    acc = r.acc;
    checkOutput({v.name, "/completed"}, r.hung, 0);
    checkOutput({v.name, "/latency"}, r.lat, v.expLat);
    checkOutput({v.name, "/resp"}, r.resp, v.expResp);
    checkOutput({v.name, "/timeout"}, r.tout, v.expTo);
    checkOutput({v.name, "/addr_valid_cycles"}, r.vCnt1, v.d1 + 1);
    checkOutput({v.name, "/rsp_ready_cycles"}, r.rdyCnt, v.d3 + 1);
    checkOutput({v.name, "/stability"}, r.stabErr, 0);
    checkOutput({v.name, "/cmd_ready_busy"}, r.busyErr, 0);
    checkOutput({v.name, "/cmd_ready_end"}, r.endReady, 1);
    if (v.isWr) checkOutput({v.name, "/wvalid_cycles"}, r.vCnt2, v.d2 + 1);
    else        checkOutput({v.name, "/rdata"}, r.data, v.expData);
  endtask

  initial begin
    vec_t tbl[9];
    vec_t wv, rv;
    int   accW, accR, mode;

    tbl[0] = mk("wr_basic",        1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 0, 0,  2'b00, 0, 2,  2'b00, 0, 32'h0);
    tbl[1] = mk("wr_aw_late",      1, 32'h14, 32'h11223344, 4'h3, 3, 0, 0,  2'b01, 0, 5,  2'b01, 0, 32'h0);
    tbl[2] = mk("wr_w_late",       1, 32'h18, 32'h55667788, 4'hC, 0, 3, 1,  2'b11, 2, 6,  2'b11, 0, 32'h0);
    tbl[3] = mk("rd_slow",         0, 32'h20, 32'hA5A5A5A5, 4'h0, 0, 0, 5,  2'b10, 4, 7,  2'b10, 0, 32'hA5A5A5A5);
    tbl[4] = mk("wr_b_at_expiry",  1, 32'h1C, 32'hCAFEF00D, 4'h5, 0, 0, 7,  2'b01, 1, 9,  2'b01, 0, 32'h0);
    tbl[5] = mk("wr_timeout",      1, 32'h24, 32'h0BADF00D, 4'hF, 0, 0, 10, 2'b00, 0, 9,  2'b10, 1, 32'h0);
    tbl[6] = mk("rd_timeout",      0, 32'h28, 32'h12345678, 4'h0, 2, 0, 12, 2'b00, 1, 11, 2'b10, 1, 32'h0);
    tbl[7] = mk("rd_r_at_expiry",  0, 32'h2C, 32'h87654321, 4'h0, 1, 0, 7,  2'b11, 0, 10, 2'b11, 0, 32'h87654321);
    tbl[8] = mk("wr_to_late_same", 1, 32'h30, 32'h00000001, 4'h1, 1, 2, 8,  2'b01, 3, 11, 2'b10, 1, 32'h0);

    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    checkOutput("reset/valid_ready", {M_AWVALID, M_WVALID, M_BREADY, M_ARVALID, M_RREADY,
                WR_RSP_VALID, RD_RSP_VALID, WR_CMD_READY, RD_CMD_READY}, 0);
    checkOutput("reset/regs", {M_AWADDR, M_WSTRB, WR_RSP_RESP, WR_RSP_TIMEOUT}, 0);
    checkOutput("reset/rd_regs", {RD_RSP_DATA, RD_RSP_RESP, RD_RSP_TIMEOUT, M_ARADDR}, 0);
    ARESETN = 1;
    #1;
    checkOutput("reset/cmd_ready_after", {WR_CMD_READY, RD_CMD_READY}, 2'b11);

    for (int i = 0; i < 9; i++) applyStimulus(tbl[i], accW);

    wv = mk("conc_wr", 1, 32'h40, 32'h0F0F0F0F, 4'h9, 1, 0, 2, 2'b00, 1, 5, 2'b00, 0, 32'h0);
    rv = mk("conc_rd", 0, 32'h44, 32'h76543210, 4'h0, 0, 0, 3, 2'b01, 0, 5, 2'b01, 0, 32'h76543210);
    fork
      applyStimulus(wv, accW);
      applyStimulus(rv, accR);
    join
    checkOutput("conc/same_accept_cycle", accW, accR);

    @(negedge ACLK);
    WR_CMD_VALID = 1; WR_CMD_ADDR = 32'h50; WR_CMD_DATA = 32'h99; WR_CMD_STRB = 4'hF;
    M_AWREADY = 0; M_WREADY = 0;
    @(negedge ACLK);
    WR_CMD_VALID = 0;
    checkOutput("rst_mid/awvalid_before", {M_AWVALID, M_WVALID}, 2'b11);
    @(negedge ACLK);
    ARESETN = 0;
    @(negedge ACLK);
    checkOutput("rst_mid/valids_cleared", {M_AWVALID, M_WVALID, M_BREADY, WR_RSP_VALID}, 0);
    checkOutput("rst_mid/cmd_ready_in_reset", WR_CMD_READY, 0);
    ARESETN = 1;
    #1;
    checkOutput("rst_mid/cmd_ready_after", WR_CMD_READY, 1);
    applyStimulus(mk("wr_after_rst", 1, 32'h54, 32'hFEEDFACE, 4'hA, 0, 1, 0, 2'b00, 0, 3, 2'b00, 0, 32'h0), accW);

    for (int i = 0; i < 30; i++) begin
      mode = $urandom_range(0, 2);
      wv.name = $sformatf("rnd%0d_wr", i); wv.isWr = 1;
      wv.addr = {22'h0, 8'($urandom_range(0, 255)), 2'b00}; wv.data = $urandom;
      wv.strb = 4'($urandom_range(0, 15));
      wv.d1 = $urandom_range(0, 3); wv.d2 = $urandom_range(0, 3); wv.d3 = $urandom_range(0, 11);
      wv.resp = 2'($urandom_range(0, 3)); wv.rspDly = $urandom_range(0, 3);
      wv = model(wv);
      rv.name = $sformatf("rnd%0d_rd", i); rv.isWr = 0;
      rv.addr = {22'h0, 8'($urandom_range(0, 255)), 2'b00}; rv.data = $urandom; rv.strb = 4'h0;
      rv.d1 = $urandom_range(0, 3); rv.d2 = 0; rv.d3 = $urandom_range(0, 11);
      rv.resp = 2'($urandom_range(0, 3)); rv.rspDly = $urandom_range(0, 3);
      rv = model(rv);
      if (mode == 0) applyStimulus(wv, accW);
      else if (mode == 1) applyStimulus(rv, accR);
      else begin
        fork
          applyStimulus(wv, accW);
          applyStimulus(rv, accR);
        join
        checkOutput($sformatf("rnd%0d/same_accept_cycle", i), accW, accR);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
